// File: rtl/piso_bidir_shift_tx.sv
// piso_bidir_shift_tx: parallel-in serial-out transmitter with selectable bit order.
// An accepted word is sent one bit per cycle, MSB first (shift_left=1) or LSB first
// (shift_left=0). bit_valid qualifies each frame bit, and done pulses for one cycle
// when the frame completes.
// Optional feature: define PARITY_EN to append an even-parity bit after the data bits.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_valid / load_ready  parallel word handshake (ready only while idle)
//   data_in, shift_left      word and direction, sampled at accept
//   serial_out, bit_valid    registered serial stream
//   busy, done               frame in progress / end-of-frame pulse
`timescale 1ns/1ps

module piso_bidir_shift_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_left,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PARITY_EN
    localparam logic [1:0] PAR   = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             so_q, so_d;
    logic             bv_q, bv_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif

    // Next-state and output logic. The first frame bit is taken straight from data_in
    // at accept so it appears in the cycle right after the accept edge.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        so_d    = 1'b0;
        bv_d    = 1'b0;
        done_d  = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    sr_d    = data_in;
                    dir_d   = shift_left;
                    cnt_d   = '0;
                    so_d    = shift_left ? data_in[WIDTH-1] : data_in[0];
                    bv_d    = 1'b1;
                    state_d = SHIFT;
`ifdef PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            SHIFT: begin
                sr_d = dir_q ? (sr_q << 1) : (sr_q >> 1);
                if (cnt_q == LAST) begin
`ifdef PARITY_EN
                    state_d = PAR;
                    so_d    = par_q;
                    bv_d    = 1'b1;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    // Next bit sits one position inward from the edge just sent.
                    cnt_d = cnt_q + CW'(1);
                    so_d  = dir_q ? sr_q[WIDTH-2] : sr_q[1];
                    bv_d  = 1'b1;
                end
            end
`ifdef PARITY_EN
            PAR: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = ~ready_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            so_q    <= 1'b0;
            bv_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            so_q    <= so_d;
            bv_q    <= bv_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign load_ready = ready_q;
    assign busy       = busy_q;
    assign serial_out = so_q;
    assign bit_valid  = bv_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_bidir_shift_tx.sv
// Self-checking bench for piso_bidir_shift_tx: directed frames followed by random
// traffic, compared cycle by cycle against a frame-schedule reference model.
`timescale 1ns/1ps

module tb_piso_bidir_shift_tx;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int N = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] data_in;
    logic         shift_left;
    logic         serial_out;
    logic         bit_valid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    piso_bidir_shift_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .shift_left (shift_left),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done)
    );

    int checks   = 0;
    int failures = 0;
    int e        = 0;   // number of rising edges seen; entry[e] is the cycle after edge e
    int free_from = 0;  // first entry index in which the transmitter is idle again

    bit exp_so   [0:N-1];
    bit exp_bv   [0:N-1];
    bit exp_done [0:N-1];

    logic [W-1:0] rx;
    int           rx_n;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s entry=%0d observed=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic lv, input logic [W-1:0] d, input logic dir);
        rst        = r;
        load_valid = lv;
        data_in    = d;
        shift_left = dir;
    endtask

    // Reference: an accept at edge e schedules the whole frame into the expectation tables.
    task automatic model_edge();
        e++;
        if (rst) begin
            for (int j = e; j < e + W + 3; j++) begin
                exp_so[j]   = 1'b0;
                exp_bv[j]   = 1'b0;
                exp_done[j] = 1'b0;
            end
            free_from = e;
        end else if (load_valid && (e - 1) >= free_from) begin
            for (int i = 0; i < W; i++) begin
                exp_so[e+i] = shift_left ? data_in[W-1-i] : data_in[i];
                exp_bv[e+i] = 1'b1;
            end
            if (P == 1) begin
                exp_so[e+W] = ^data_in;
                exp_bv[e+W] = 1'b1;
            end
            exp_done[e+W+P] = 1'b1;
            free_from = e + W + P;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("serial_out", serial_out, exp_so[e]);
        chk("bit_valid",  bit_valid,  exp_bv[e]);
        chk("done",       done,       exp_done[e]);
        chk("load_ready", load_ready, e >= free_from);
        chk("busy",       busy,       e < free_from);
        if (bit_valid && rx_n < W) begin
            rx = {serial_out, rx[W-1:1]};
            rx_n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < N; j++) begin
            exp_so[j]   = 1'b0;
            exp_bv[j]   = 1'b0;
            exp_done[j] = 1'b0;
        end
        rx   = '0;
        rx_n = W;

        // Reset held two cycles with a word offered: nothing is accepted.
        drive(1'b1, 1'b1, 4'b1011, 1'b1);
        repeat (2) cycle();

        // MSB first.
        drive(1'b0, 1'b1, 4'b1011, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 4'b0000, 1'b0);
        repeat (W + P + 2) cycle();

        // LSB first, with a receiver shifting right on bit_valid.
        rx   = '0;
        rx_n = 0;
        drive(1'b0, 1'b1, 4'b1011, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 4'b0110, 1'b1);
        repeat (W + P + 2) cycle();
        checks++;
        assert (rx === 4'b1011) else begin
            failures++;
            $error("FAIL lsb_receiver observed=%b expected=%b", rx, 4'b1011);
        end

        // Back-to-back frames, with input changes while busy.
        drive(1'b0, 1'b1, 4'hA, 1'b1);
        cycle();
        drive(1'b0, 1'b1, 4'h5, 1'b1);
        repeat (W + P + 1) cycle();
        drive(1'b0, 1'b0, 4'h3, 1'b0);
        repeat (W + P + 3) cycle();

        // Reset after two bits of 4'hF.
        drive(1'b0, 1'b1, 4'hF, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 4'hF, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 4'hF, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        repeat (W + P + 4) cycle();

        // Random traffic with occasional resets.
        rx_n = W;
        repeat (300) begin
            drive($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)),
                  W'($urandom), 1'($urandom_range(0, 1)));
            cycle();
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        repeat (W + P + 4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
